// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter: round-robin, burst-limited sharing of an async-FIFO read port; FIFO_RD_ARB_PRIO_EN gives requester 0 priority
module fifo_rd_arbiter #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int NREQ  = 4,
  parameter int BURST = 4
) (
  input  logic                    r_clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic                    empty,
  input  logic [WIDTH-1:0]        rdata,
  output logic                    rd_rq,
  output logic [NREQ-1:0]         gnt,
  output logic [WIDTH-1:0]        dout,
  output logic                    dout_valid,
  output logic [$clog2(NREQ)-1:0] dout_id
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(BURST + 1);
  if (NREQ < 2 || BURST < 1 || DEPTH < 1) begin : g_bad_cfg
    $error("fifo_rd_arbiter: invalid NREQ/BURST/DEPTH");
  end
  typedef enum logic {IDLE, GRANT} state_t;
  state_t          state, state_nxt;
  logic [IW-1:0]   owner, owner_nxt, rr_ptr, rr_ptr_nxt, rr_pick, pick;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [NREQ-1:0] gnt_nxt;
  logic            pop, rel, prio_win, prio_nxt, win0;
  // Scan downwards so the first requester in rr_ptr order is written last and wins
  always_comb begin
    rr_pick = '0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (req[(int'(rr_ptr) + i) % NREQ]) rr_pick = IW'((int'(rr_ptr) + i) % NREQ);
  end
`ifdef FIFO_RD_ARB_PRIO_EN
  // Only a win that round-robin would not have given freezes rr_ptr
  assign win0 = req[0] & (rr_pick != '0);
`else
  assign win0 = 1'b0;
`endif
  assign pick  = win0 ? '0 : rr_pick;
  assign rd_rq = (state == GRANT) & req[owner] & ~empty & ~rst;
  assign pop   = rd_rq & ~empty;
  assign rel   = (pop & (cnt == CW'(BURST - 1))) | ~req[owner] | (empty & ~pop);
  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    rr_ptr_nxt = rr_ptr;
    cnt_nxt    = cnt;
    gnt_nxt    = gnt;
    prio_nxt   = prio_win;
    if (state == IDLE) begin
      if (|req & ~empty) begin
        state_nxt = GRANT;
        owner_nxt = pick;
        gnt_nxt   = NREQ'(1) << pick;
        cnt_nxt   = '0;
        prio_nxt  = win0;
      end
    end else if (rel) begin
      state_nxt  = IDLE;
      gnt_nxt    = '0;
      rr_ptr_nxt = prio_win ? rr_ptr : (owner == IW'(NREQ - 1) ? '0 : owner + 1'b1);
    end else if (pop) begin
      cnt_nxt = cnt + 1'b1;
    end
  end
  always_ff @(posedge r_clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= '0;
      rr_ptr     <= '0;
      cnt        <= '0;
      gnt        <= '0;
      prio_win   <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_id    <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      rr_ptr     <= rr_ptr_nxt;
      cnt        <= cnt_nxt;
      gnt        <= gnt_nxt;
      prio_win   <= prio_nxt;
      dout_valid <= pop;
      if (pop) begin
        dout    <= rdata;
        dout_id <= owner;
      end
    end
  end
endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// tb_fifo_rd_arbiter: table-driven and directed checks of fifo_rd_arbiter against a bench-side FIFO model
module tb_fifo_rd_arbiter;
`ifdef FIFO_RD_ARB_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif
  logic       r_clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic       empty, rd_rq, dout_valid;
  logic [3:0] rdata, gnt, dout;
  logic [1:0] dout_id;
  logic [3:0] mem [64];
  int         head = 0, tail = 0;
  int         checks = 0, failures = 0;
  always #5 r_clk = ~r_clk;
  assign empty = (head == tail);
  assign rdata = mem[head[5:0]];
  fifo_rd_arbiter #(.WIDTH(4), .DEPTH(8), .NREQ(4), .BURST(4)) dut (
    .r_clk(r_clk), .rst(rst), .req(req), .empty(empty), .rdata(rdata),
    .rd_rq(rd_rq), .gnt(gnt), .dout(dout), .dout_valid(dout_valid), .dout_id(dout_id)
  );
  typedef struct {
    logic       r;
    logic [3:0] rq;
    logic       e_rq;
    logic [3:0] e_gnt;
    logic       e_dv;
    logic [3:0] e_d;
    logic [1:0] e_id;
  } vec_t;
  vec_t tbl [11];
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  task automatic push(input logic [3:0] w);
    mem[tail[5:0]] = w;
    tail++;
  endtask
  task automatic flush();
    head = tail;
  endtask
  // One clock: drive, check rd_rq before the edge, advance the FIFO on a pop, check registered outputs after
  task automatic cyc(input logic r, input logic [3:0] rq, input logic e_rq, input logic [3:0] e_gnt,
                     input logic e_dv, input logic [3:0] e_d, input logic [1:0] e_id, input string nm);
    logic p;
    rst = r;
    req = rq;
    #2;
    chk({nm, "_rd_rq"}, int'(rd_rq), int'(e_rq));
    p = rd_rq & ~empty;
    @(posedge r_clk);
    #1;
    if (p) head++;
    chk({nm, "_gnt"}, int'(gnt), int'(e_gnt));
    chk({nm, "_dv"}, int'(dout_valid), int'(e_dv));
    if (e_dv) begin
      chk({nm, "_dout"}, int'(dout), int'(e_d));
      chk({nm, "_id"}, int'(dout_id), int'(e_id));
    end
    if (r) begin
      chk({nm, "_rst_dout"}, int'(dout), 0);
      chk({nm, "_rst_id"}, int'(dout_id), 0);
    end
  endtask
  initial begin
    int d;
    int order [6] = '{0, 1, 3, 0, 1, 3};
    logic [3:0] oh;
    tbl[0]  = '{1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 4'h0, 2'd0};
    tbl[1]  = '{1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 4'h0, 2'd0};
    tbl[2]  = '{1'b0, 4'h4, 1'b0, 4'h4, 1'b0, 4'h0, 2'd0};
    tbl[3]  = '{1'b0, 4'h4, 1'b1, 4'h4, 1'b1, 4'hA, 2'd2};
    tbl[4]  = '{1'b0, 4'h4, 1'b1, 4'h4, 1'b1, 4'hB, 2'd2};
    tbl[5]  = '{1'b0, 4'h4, 1'b1, 4'h4, 1'b1, 4'hC, 2'd2};
    tbl[6]  = '{1'b0, 4'h4, 1'b1, 4'h0, 1'b1, 4'hD, 2'd2};
    tbl[7]  = '{1'b0, 4'h4, 1'b0, 4'h4, 1'b0, 4'h0, 2'd0};
    tbl[8]  = '{1'b0, 4'h4, 1'b1, 4'h4, 1'b1, 4'hE, 2'd2};
    tbl[9]  = '{1'b0, 4'h4, 1'b1, 4'h4, 1'b1, 4'hF, 2'd2};
    tbl[10] = '{1'b0, 4'h4, 1'b0, 4'h0, 1'b0, 4'h0, 2'd0};
    for (int i = 0; i < 6; i++) push(4'(10 + i));
    for (int i = 0; i < 11; i++)
      cyc(tbl[i].r, tbl[i].rq, tbl[i].e_rq, tbl[i].e_gnt, tbl[i].e_dv, tbl[i].e_d, tbl[i].e_id,
          $sformatf("burst%0d", i));
    cyc(1'b1, 4'hB, 1'b0, 4'h0, 1'b0, 4'h0, 2'd0, "rr_rst");
    flush();
    for (int i = 0; i < 30; i++) push(4'(i));
    d = 0;
    for (int g = 0; g < 6; g++) begin
      oh = 4'(1 << order[g]);
      cyc(1'b0, 4'hB, 1'b0, oh, 1'b0, 4'h0, 2'd0, $sformatf("rr%0d_idle", g));
      for (int j = 0; j < 4; j++) begin
        cyc(1'b0, 4'hB, 1'b1, (j == 3) ? 4'h0 : oh, 1'b1, 4'(d), 2'(order[g]), $sformatf("rr%0d_pop%0d", g, j));
        d++;
      end
    end
    cyc(1'b1, 4'h1, 1'b0, 4'h0, 1'b0, 4'h0, 2'd0, "emp_rst");
    flush();
    push(4'h5);
    push(4'h6);
    cyc(1'b0, 4'h1, 1'b0, 4'h1, 1'b0, 4'h0, 2'd0, "emp_gnt");
    cyc(1'b0, 4'h1, 1'b1, 4'h1, 1'b1, 4'h5, 2'd0, "emp_pop0");
    cyc(1'b0, 4'h1, 1'b1, 4'h1, 1'b1, 4'h6, 2'd0, "emp_pop1");
    cyc(1'b0, 4'h1, 1'b0, 4'h0, 1'b0, 4'h0, 2'd0, "emp_rel");
    cyc(1'b0, 4'h1, 1'b0, 4'h0, 1'b0, 4'h0, 2'd0, "emp_hold");
    push(4'h7);
    cyc(1'b0, 4'h3, 1'b0, PRIO ? 4'h1 : 4'h2, 1'b0, 4'h0, 2'd0, "emp_regnt");
    cyc(1'b0, 4'h3, 1'b1, PRIO ? 4'h1 : 4'h2, 1'b1, 4'h7, PRIO ? 2'd0 : 2'd1, "emp_pop2");
    cyc(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 2'd0, "drop_rst");
    flush();
    push(4'h8);
    push(4'h9);
    push(4'hA);
    push(4'hB);
    cyc(1'b0, 4'h2, 1'b0, 4'h2, 1'b0, 4'h0, 2'd0, "drop_gnt");
    cyc(1'b0, 4'h2, 1'b1, 4'h2, 1'b1, 4'h8, 2'd1, "drop_pop");
    cyc(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 2'd0, "drop_rel");
    cyc(1'b0, 4'h2, 1'b0, 4'h2, 1'b0, 4'h0, 2'd0, "drop_regnt");
    cyc(1'b0, 4'h2, 1'b1, 4'h2, 1'b1, 4'h9, 2'd1, "drop_pop1");
    cyc(1'b1, 4'h2, 1'b0, 4'h0, 1'b0, 4'h0, 2'd0, "drop_midrst");
    cyc(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 2'd0, "drop_after");
    chk("drop_no_pop_in_rst", int'(rdata), 'hA);
`ifdef FIFO_RD_ARB_PRIO_EN
    cyc(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 2'd0, "prio_rst");
    flush();
    for (int i = 0; i < 20; i++) push(4'(i));
    cyc(1'b0, 4'h1, 1'b0, 4'h1, 1'b0, 4'h0, 2'd0, "prio_gnt0");
    cyc(1'b0, 4'h1, 1'b1, 4'h1, 1'b1, 4'h0, 2'd0, "prio_pop0");
    cyc(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 2'd0, "prio_rel");
    d = 1;
    for (int g = 0; g < 3; g++) begin
      cyc(1'b0, 4'h3, 1'b0, 4'h1, 1'b0, 4'h0, 2'd0, $sformatf("prio%0d_idle", g));
      for (int j = 0; j < 4; j++) begin
        cyc(1'b0, 4'h3, 1'b1, (j == 3) ? 4'h0 : 4'h1, 1'b1, 4'(d), 2'd0, $sformatf("prio%0d_pop%0d", g, j));
        d++;
      end
    end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
